// File: rtl/conv1x1_if.sv
// Activation stream, weight/bias ROM ports and result stream of the 1x1 convolution engine.
// The engine connects through the master modport; the feeder/ROM/consumer side uses slave.
interface conv1x1_if #(
  parameter int DSP_NO = 128,
  parameter int WIDTH  = 16,
  parameter int WA_W   = 5,
  parameter int BA_W   = 1
);
  logic [WIDTH-1:0]        ifm;
  logic                    ifm_valid;
  logic                    ifm_ready;
  logic [WA_W-1:0]         w_addr;
  logic [DSP_NO*WIDTH-1:0] w_data;
  logic [BA_W-1:0]         b_addr;
  logic [DSP_NO*WIDTH-1:0] b_data;
  logic [DSP_NO*WIDTH-1:0] ofm;
  logic [BA_W-1:0]         ofm_group;
  logic                    ofm_valid;
  logic                    ofm_ready;

  modport master (
    input  ifm, ifm_valid, w_data, b_data, ofm_ready,
    output ifm_ready, w_addr, b_addr, ofm, ofm_group, ofm_valid
  );

  modport slave (
    output ifm, ifm_valid, w_data, b_data, ofm_ready,
    input  ifm_ready, w_addr, b_addr, ofm, ofm_group, ofm_valid
  );
endinterface

// File: rtl/conv1x1_engine.sv
// 1x1 convolution engine: buffers CHIN activations per pixel and produces CHOUT results
// in groups of DSP_NO lanes with bias, rounding shift, optional ReLU and saturation.
module conv1x1_engine #(
  parameter int DSP_NO  = 128,
  parameter int CHIN    = 32,
  parameter int CHOUT   = 128,
  parameter int PIXELS  = 1024,
  parameter int WIDTH   = 16,
  parameter int FRAC    = 8,
  parameter bit RELU_EN = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      start,
  output logic      busy,
  output logic      layer_end,
  conv1x1_if.master bus
);
  localparam int GROUPS = CHOUT / DSP_NO;
  localparam int WA_W   = (GROUPS * CHIN > 1) ? $clog2(GROUPS * CHIN) : 1;
  localparam int BA_W   = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int CIN_W  = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int PIX_W  = (PIXELS > 1) ? $clog2(PIXELS) : 1;
  localparam int PROD_W = 2 * WIDTH;
  localparam int ACC_W  = 2 * WIDTH + $clog2(CHIN);
  localparam int RND_W  = ACC_W + 1;

  localparam logic signed [RND_W-1:0] ROUND_HALF = RND_W'(2 ** (FRAC - 1));
  localparam logic signed [RND_W-1:0] SAT_MAX    = RND_W'(2 ** (WIDTH - 1) - 1);
  localparam logic signed [RND_W-1:0] SAT_MIN    = RND_W'(-(2 ** (WIDTH - 1)));

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, REPLAY} state_t;

  state_t state, next_state;

  logic [CIN_W-1:0] cin;
  logic [BA_W-1:0]  group;
  logic [PIX_W-1:0] pixel;
  logic             last_cin, last_group, last_pixel;
  logic             mac_en, load_ready;

  logic signed [WIDTH-1:0]  buffer [CHIN];
  logic signed [WIDTH-1:0]  mac_in;
  logic signed [WIDTH-1:0]  wgt [DSP_NO];
  logic signed [WIDTH-1:0]  bia [DSP_NO];
  logic signed [PROD_W-1:0] prod [DSP_NO];
  logic signed [ACC_W-1:0]  acc_sum [DSP_NO];
  logic signed [ACC_W-1:0]  acc_p0 [DSP_NO];
  logic [DSP_NO*WIDTH-1:0]  res_flat;

  logic [DSP_NO*WIDTH-1:0]  ofm_p1;
  logic [BA_W-1:0]          ofm_group_p1;
  logic                     vld_p1;

  function automatic logic signed [RND_W-1:0] round_shift(
    input logic signed [ACC_W-1:0] acc,
    input logic signed [WIDTH-1:0] bias
  );
    logic signed [RND_W-1:0] sum;
    sum = RND_W'(acc) + (RND_W'(bias) <<< FRAC) + ROUND_HALF;
    return sum >>> FRAC;
  endfunction

  function automatic logic signed [WIDTH-1:0] saturate(input logic signed [RND_W-1:0] v);
    if (RELU_EN && v < 0) return '0;
    if (v > SAT_MAX) return {1'b0, {(WIDTH-1){1'b1}}};
    if (v < SAT_MIN) return {1'b1, {(WIDTH-1){1'b0}}};
    return v[WIDTH-1:0];
  endfunction

  assign last_cin   = (cin == CIN_W'(CHIN - 1));
  assign last_group = (group == BA_W'(GROUPS - 1));
  assign last_pixel = (pixel == PIX_W'(PIXELS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    mac_en     = 1'b0;
    load_ready = 1'b0;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        mac_en     = bus.ifm_valid;
        if (bus.ifm_valid && last_cin) next_state = DRAIN;
      end
      REPLAY: begin
        mac_en = 1'b1;
        if (last_cin) next_state = DRAIN;
      end
      DRAIN: begin
        if (bus.ofm_ready) begin
          if (!last_group)      next_state = REPLAY;
          else if (!last_pixel) next_state = LOAD;
          else                  next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign busy          = (state != IDLE);
  assign bus.ifm_ready = load_ready;
  // In LOAD the group is always 0, so one address formula serves both MAC sources.
  assign bus.w_addr    = WA_W'(group * CHIN + cin);
  assign bus.b_addr    = group;
  assign bus.ofm       = ofm_p1;
  assign bus.ofm_group = ofm_group_p1;
  assign bus.ofm_valid = vld_p1;

  // Stage p0: multiply-accumulate; cin==0 restarts the sum for every group.
  always_comb begin
    logic signed [ACC_W-1:0] acc_base;
    mac_in   = (state == LOAD) ? $signed(bus.ifm) : buffer[cin];
    res_flat = '0;
    acc_base = '0;
    for (int l = 0; l < DSP_NO; l++) begin
      wgt[l]     = $signed(bus.w_data[l*WIDTH +: WIDTH]);
      bia[l]     = $signed(bus.b_data[l*WIDTH +: WIDTH]);
      prod[l]    = PROD_W'(mac_in) * PROD_W'(wgt[l]);
      acc_base   = (cin == '0) ? '0 : acc_p0[l];
      acc_sum[l] = acc_base + ACC_W'(prod[l]);
      res_flat[l*WIDTH +: WIDTH] = saturate(round_shift(acc_sum[l], bia[l]));
    end
  end

  always_ff @(posedge clk) begin
    if (state == LOAD && bus.ifm_valid) buffer[cin] <= $signed(bus.ifm);
    if (mac_en) begin
      for (int l = 0; l < DSP_NO; l++) acc_p0[l] <= acc_sum[l];
    end
  end

  // Stage p1: result register, captured on the final MAC of a group and held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      cin          <= '0;
      group        <= '0;
      pixel        <= '0;
      layer_end    <= 1'b0;
      vld_p1       <= 1'b0;
      ofm_p1       <= '0;
      ofm_group_p1 <= '0;
    end else begin
      if (state == IDLE && start) begin
        layer_end <= 1'b0;
        cin       <= '0;
        group     <= '0;
        pixel     <= '0;
      end
      if (mac_en) begin
        cin <= last_cin ? '0 : cin + CIN_W'(1);
        if (last_cin) begin
          vld_p1       <= 1'b1;
          ofm_p1       <= res_flat;
          ofm_group_p1 <= group;
        end
      end
      if (state == DRAIN && bus.ofm_ready) begin
        vld_p1 <= 1'b0;
        if (!last_group) begin
          group <= group + BA_W'(1);
        end else begin
          group <= '0;
          if (last_pixel) begin
            pixel     <= '0;
            layer_end <= 1'b1;
          end else begin
            pixel <= pixel + PIX_W'(1);
          end
        end
      end
    end
  end
endmodule
